// File: rtl/id_pkg.sv
// Shared decode definitions: opcodes, instruction classes, immediate formats, FSM states.
package id_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Canonical NOP (addi x0, x0, 0) held after reset.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } instr_class_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  typedef enum logic {
    WAIT_INSTR = 1'b0,
    PROVIDE    = 1'b1
  } id_state_e;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator: sign-extends from instr[31] per format.
module id_imm_gen
  import id_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate bits for each encoding format.
  always_comb begin
    imm = 32'h0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'h000};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: take one instruction from fetch, hold it, offer the decoded bundle to execute.
module id_stage
  import id_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               IF_ID_give_i,
  input  logic [31:0]        IF_ID_instr_i,
  output logic               ID_IF_get_o,
  input  logic               EX_ID_get_i,
  output logic               ID_EX_give_o,
  output logic [3:0]         ID_EX_class_o,
  output logic [4:0]         ID_EX_rd_o,
  output logic [4:0]         ID_EX_rs1_o,
  output logic [4:0]         ID_EX_rs2_o,
  output logic [2:0]         ID_EX_funct3_o,
  output logic               ID_EX_funct7b5_o,
  output logic [BITSIZE-1:0] ID_EX_imm_o,
  output logic               ID_EX_illegal_o
);

  id_state_e    state_q, state_d;
  logic [31:0]  instr_q;
  logic         capture;
  instr_class_e cls;
  imm_fmt_e     fmt;
  logic         illegal;
  logic [31:0]  imm_raw;

  // State and instruction register; reset loads a NOP so decode outputs are benign.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= WAIT_INSTR;
      instr_q <= INSTR_NOP;
    end else begin
      state_q <= state_d;
      if (capture) instr_q <= IF_ID_instr_i;
    end
  end

  // Handshake FSM; both handshake outputs are suppressed while reset is asserted
  // so neither neighbour sees a transfer that is about to be discarded.
  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    ID_IF_get_o  = 1'b0;
    ID_EX_give_o = 1'b0;
    case (state_q)
      WAIT_INSTR: begin
        ID_IF_get_o = 1'b1;
        if (IF_ID_give_i) begin
          capture = 1'b1;
          state_d = PROVIDE;
        end
      end
      PROVIDE: begin
        ID_EX_give_o = EX_ID_get_i;
        if (EX_ID_get_i) state_d = WAIT_INSTR;
      end
      default: state_d = WAIT_INSTR;
    endcase
    if (reset_i) begin
      ID_IF_get_o  = 1'b0;
      ID_EX_give_o = 1'b0;
    end
  end

  // Opcode decode into class and immediate format; anything unlisted is illegal.
  // Every listed opcode ends in 2'b11, so a bad low pair also falls to the default.
  always_comb begin
    cls     = CLS_ILLEGAL;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (instr_q[6:0])
      OPC_LUI:      begin cls = CLS_LUI;    fmt = FMT_U; end
      OPC_AUIPC:    begin cls = CLS_AUIPC;  fmt = FMT_U; end
      OPC_JAL:      begin cls = CLS_JAL;    fmt = FMT_J; end
      OPC_JALR:     begin cls = CLS_JALR;   fmt = FMT_I; end
      OPC_BRANCH:   begin cls = CLS_BRANCH; fmt = FMT_B; end
      OPC_LOAD:     begin cls = CLS_LOAD;   fmt = FMT_I; end
      OPC_STORE:    begin cls = CLS_STORE;  fmt = FMT_S; end
      OPC_OPIMM:    begin cls = CLS_OPIMM;  fmt = FMT_I; end
      OPC_OP:       begin cls = CLS_OP;     fmt = FMT_R; end
      OPC_MISC_MEM: begin cls = CLS_FENCE;  fmt = FMT_I; end
      OPC_SYSTEM:   begin cls = CLS_SYSTEM; fmt = FMT_I; end
      default:      begin cls = CLS_ILLEGAL; fmt = FMT_R; illegal = 1'b1; end
    endcase
  end

  id_imm_gen u_imm_gen (
    .instr (instr_q),
    .fmt   (fmt),
    .imm   (imm_raw)
  );

  assign ID_EX_class_o    = cls;
  assign ID_EX_illegal_o  = illegal;
  assign ID_EX_imm_o      = illegal ? '0 : imm_raw[BITSIZE-1:0];
  assign ID_EX_rd_o       = instr_q[11:7];
  assign ID_EX_rs1_o      = instr_q[19:15];
  assign ID_EX_rs2_o      = instr_q[24:20];
  assign ID_EX_funct3_o   = instr_q[14:12];
  assign ID_EX_funct7b5_o = instr_q[30];

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: handshake timing, decode fields, reset behaviour.
module tb_id_stage;

  localparam logic [3:0] C_LUI = 4'd0, C_JAL = 4'd2, C_BRANCH = 4'd4, C_STORE = 4'd6,
                         C_OPIMM = 4'd7, C_OP = 4'd8, C_ILLEGAL = 4'd11;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        IF_ID_give_i = 1'b0;
  logic [31:0] IF_ID_instr_i = 32'h0;
  logic        ID_IF_get_o;
  logic        EX_ID_get_i = 1'b0;
  logic        ID_EX_give_o;
  logic [3:0]  ID_EX_class_o;
  logic [4:0]  ID_EX_rd_o, ID_EX_rs1_o, ID_EX_rs2_o;
  logic [2:0]  ID_EX_funct3_o;
  logic        ID_EX_funct7b5_o;
  logic [31:0] ID_EX_imm_o;
  logic        ID_EX_illegal_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_stage #(.BITSIZE(32)) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .IF_ID_give_i     (IF_ID_give_i),
    .IF_ID_instr_i    (IF_ID_instr_i),
    .ID_IF_get_o      (ID_IF_get_o),
    .EX_ID_get_i      (EX_ID_get_i),
    .ID_EX_give_o     (ID_EX_give_o),
    .ID_EX_class_o    (ID_EX_class_o),
    .ID_EX_rd_o       (ID_EX_rd_o),
    .ID_EX_rs1_o      (ID_EX_rs1_o),
    .ID_EX_rs2_o      (ID_EX_rs2_o),
    .ID_EX_funct3_o   (ID_EX_funct3_o),
    .ID_EX_funct7b5_o (ID_EX_funct7b5_o),
    .ID_EX_imm_o      (ID_EX_imm_o),
    .ID_EX_illegal_o  (ID_EX_illegal_o)
  );

  // Offer one instruction for a single cycle; returns at the negedge of the
  // following cycle, when the DUT should be in PROVIDE.
  task automatic give_instr(input logic [31:0] w);
    @(negedge clk);
    IF_ID_give_i  = 1'b1;
    IF_ID_instr_i = w;
    @(negedge clk);
    IF_ID_give_i  = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    n_chk++; if (ID_IF_get_o !== 1'b1) begin n_fail++; $display("FAIL reset_get: got %0b want 1", ID_IF_get_o); end
    n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL reset_give: got %0b want 0", ID_EX_give_o); end
    n_chk++; if (ID_EX_illegal_o !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %0b want 0", ID_EX_illegal_o); end
    n_chk++; if (ID_EX_class_o !== C_OPIMM) begin n_fail++; $display("FAIL reset_class: got %0d want %0d", ID_EX_class_o, C_OPIMM); end
  endtask

  task automatic test_lui();
    give_instr(32'h7C7F_E2B7);
    EX_ID_get_i = 1'b1;
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b1) begin n_fail++; $display("FAIL lui_give: got %0b want 1", ID_EX_give_o); end
    n_chk++; if (ID_IF_get_o !== 1'b0) begin n_fail++; $display("FAIL lui_get: got %0b want 0", ID_IF_get_o); end
    n_chk++; if (ID_EX_class_o !== C_LUI) begin n_fail++; $display("FAIL lui_class: got %0d want %0d", ID_EX_class_o, C_LUI); end
    n_chk++; if (ID_EX_rd_o !== 5'd5) begin n_fail++; $display("FAIL lui_rd: got %0d want 5", ID_EX_rd_o); end
    n_chk++; if (ID_EX_imm_o !== 32'h7C7F_E000) begin n_fail++; $display("FAIL lui_imm: got %h want 7c7fe000", ID_EX_imm_o); end
    n_chk++; if (ID_EX_illegal_o !== 1'b0) begin n_fail++; $display("FAIL lui_illegal: got %0b want 0", ID_EX_illegal_o); end
    @(negedge clk);
    EX_ID_get_i = 1'b0;
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL lui_give_once: got %0b want 0", ID_EX_give_o); end
    n_chk++; if (ID_IF_get_o !== 1'b1) begin n_fail++; $display("FAIL lui_get_back: got %0b want 1", ID_IF_get_o); end
  endtask

  // Execute holds get high throughout: one handoff per instruction, back-to-back.
  task automatic test_back_to_back();
    EX_ID_get_i = 1'b1;
    @(negedge clk);
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_give: got %0b want 0", ID_EX_give_o); end
    give_instr(32'h0011_8193);
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b1) begin n_fail++; $display("FAIL opimm_give: got %0b want 1", ID_EX_give_o); end
    n_chk++; if (ID_EX_class_o !== C_OPIMM) begin n_fail++; $display("FAIL opimm_class: got %0d want %0d", ID_EX_class_o, C_OPIMM); end
    n_chk++; if (ID_EX_rd_o !== 5'd3) begin n_fail++; $display("FAIL opimm_rd: got %0d want 3", ID_EX_rd_o); end
    n_chk++; if (ID_EX_rs1_o !== 5'd3) begin n_fail++; $display("FAIL opimm_rs1: got %0d want 3", ID_EX_rs1_o); end
    n_chk++; if (ID_EX_funct3_o !== 3'd0) begin n_fail++; $display("FAIL opimm_funct3: got %0d want 0", ID_EX_funct3_o); end
    n_chk++; if (ID_EX_imm_o !== 32'h1) begin n_fail++; $display("FAIL opimm_imm: got %h want 00000001", ID_EX_imm_o); end
    give_instr(32'h0020_81B3);
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b1) begin n_fail++; $display("FAIL add_give: got %0b want 1", ID_EX_give_o); end
    n_chk++; if (ID_EX_class_o !== C_OP) begin n_fail++; $display("FAIL add_class: got %0d want %0d", ID_EX_class_o, C_OP); end
    n_chk++; if (ID_EX_rs2_o !== 5'd2) begin n_fail++; $display("FAIL add_rs2: got %0d want 2", ID_EX_rs2_o); end
    n_chk++; if (ID_EX_imm_o !== 32'h0) begin n_fail++; $display("FAIL add_imm: got %h want 00000000", ID_EX_imm_o); end
    @(negedge clk);
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL b2b_give_once: got %0b want 0", ID_EX_give_o); end
    n_chk++; if (ID_IF_get_o !== 1'b1) begin n_fail++; $display("FAIL b2b_get_back: got %0b want 1", ID_IF_get_o); end
    EX_ID_get_i = 1'b0;
  endtask

  // Execute stalls 5 cycles while fetch keeps offering a different word.
  task automatic test_stall();
    give_instr(32'hFC7F_E2B7);
    for (int i = 0; i < 5; i++) begin
      IF_ID_give_i  = 1'b1;
      IF_ID_instr_i = 32'h0000_0000;
      #1;
      n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL stall_give[%0d]: got %0b want 0", i, ID_EX_give_o); end
      n_chk++; if (ID_IF_get_o !== 1'b0) begin n_fail++; $display("FAIL stall_get[%0d]: got %0b want 0", i, ID_IF_get_o); end
      n_chk++; if (ID_EX_imm_o !== 32'hFC7F_E000) begin n_fail++; $display("FAIL stall_imm[%0d]: got %h want fc7fe000", i, ID_EX_imm_o); end
      @(negedge clk);
    end
    IF_ID_give_i = 1'b0;
    EX_ID_get_i  = 1'b1;
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %0b want 1", ID_EX_give_o); end
    n_chk++; if (ID_EX_imm_o !== 32'hFC7F_E000) begin n_fail++; $display("FAIL stall_final_imm: got %h want fc7fe000", ID_EX_imm_o); end
    n_chk++; if (ID_EX_class_o !== C_LUI) begin n_fail++; $display("FAIL stall_class: got %0d want %0d", ID_EX_class_o, C_LUI); end
    @(negedge clk);
    EX_ID_get_i = 1'b0;
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL stall_give_once: got %0b want 0", ID_EX_give_o); end
    n_chk++; if (ID_IF_get_o !== 1'b1) begin n_fail++; $display("FAIL stall_get_back: got %0b want 1", ID_IF_get_o); end
  endtask

  // Directed format table: branch, jal, store, zero word, bad low bits.
  task automatic test_formats();
    logic [31:0] w   [5] = '{32'hFE00_0EE3, 32'h0080_00EF, 32'hFE11_2E23, 32'h0000_0000, 32'h0000_0012};
    logic [3:0]  cls [5] = '{C_BRANCH, C_JAL, C_STORE, C_ILLEGAL, C_ILLEGAL};
    logic [31:0] imm [5] = '{32'hFFFF_FFFC, 32'h0000_0008, 32'hFFFF_FFFC, 32'h0, 32'h0};
    logic        ill [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      give_instr(w[i]);
      EX_ID_get_i = 1'b1;
      #1;
      n_chk++; if (ID_EX_class_o !== cls[i]) begin n_fail++; $display("FAIL fmt_class[%0d]: got %0d want %0d", i, ID_EX_class_o, cls[i]); end
      n_chk++; if (ID_EX_imm_o !== imm[i]) begin n_fail++; $display("FAIL fmt_imm[%0d]: got %h want %h", i, ID_EX_imm_o, imm[i]); end
      n_chk++; if (ID_EX_illegal_o !== ill[i]) begin n_fail++; $display("FAIL fmt_illegal[%0d]: got %0b want %0b", i, ID_EX_illegal_o, ill[i]); end
      n_chk++; if (ID_EX_give_o !== 1'b1) begin n_fail++; $display("FAIL fmt_give[%0d]: got %0b want 1", i, ID_EX_give_o); end
      @(negedge clk);
      EX_ID_get_i = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    give_instr(32'h7C7F_E2B7);
    EX_ID_get_i = 1'b1;
    reset_i     = 1'b1;
    #1;
    n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_give: got %0b want 0", ID_EX_give_o); end
    @(negedge clk);
    reset_i     = 1'b0;
    EX_ID_get_i = 1'b0;
    #1;
    n_chk++; if (ID_IF_get_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_get: got %0b want 1", ID_IF_get_o); end
    n_chk++; if (ID_EX_give_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_give_after: got %0b want 0", ID_EX_give_o); end
    n_chk++; if (ID_EX_class_o !== C_OPIMM) begin n_fail++; $display("FAIL rstmid_nop_class: got %0d want %0d", ID_EX_class_o, C_OPIMM); end
    n_chk++; if (ID_EX_imm_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_nop_imm: got %h want 00000000", ID_EX_imm_o); end
  endtask

  initial begin
    test_reset();
    test_lui();
    test_back_to_back();
    test_stall();
    test_formats();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode pipeline stage. It pulls one 32-bit RV32I instruction from the fetch stage over the give/get handshake, registers it, and decodes it into register indices, function fields, a sign-extended immediate and an instruction class. It then offers the decoded bundle to the execute stage over the same give/get handshake. It sits between fetch and execute and is the consumer end of the fetch-to-decode interface.

## Interface
Parameters:
- BITSIZE, 32: data/immediate width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock; the block uses this single clock only.
- reset_i  input  1  synchronous reset, active-high.
- IF_ID_give_i  input  1  fetch offers an instruction this cycle.
- IF_ID_instr_i  input  32  instruction word; valid only when IF_ID_give_i is high.
- ID_IF_get_o  output  1  decode requests an instruction.
- EX_ID_get_i  input  1  execute requests a decoded bundle.
- ID_EX_give_o  output  1  decoded bundle handed over this cycle.
- ID_EX_class_o  output  4  instruction class (package enum).
- ID_EX_rd_o / ID_EX_rs1_o / ID_EX_rs2_o  output  5 each  register indices.
- ID_EX_funct3_o  output  3  instr[14:12].
- ID_EX_funct7b5_o  output  1  instr[30].
- ID_EX_imm_o  output  32  sign-extended immediate.
- ID_EX_illegal_o  output  1  unsupported encoding.

## Operation
- FSM states: WAIT_INSTR, PROVIDE.
- WAIT_INSTR: ID_IF_get_o = 1. If IF_ID_give_i = 1, capture IF_ID_instr_i into instr_q and go to PROVIDE. Otherwise stay.
- PROVIDE: ID_IF_get_o = 0. ID_EX_give_o = EX_ID_get_i, combinationally, mirroring the fetch-side convention. When EX_ID_get_i = 1 the transfer completes and the FSM returns to WAIT_INSTR. Otherwise hold.
- All decode outputs are combinational from instr_q. They are stable for the whole PROVIDE period and are don't-care in WAIT_INSTR.
- Class and immediate are selected by opcode instr_q[6:0]:
  - LUI 0110111 and AUIPC 0010111: U-type, {instr[31:12], 12'b0}.
  - JAL 1101111: J-type.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: I-type.
  - STORE 0100011: S-type.
  - BRANCH 1100011: B-type.
  - OP 0110011: R-type, imm = 0.
  - MISC-MEM 0001111 and SYSTEM 1110011: I-type.
- Every immediate is sign-extended from instr[31]. B and J immediates have bit 0 = 0.
- rd, rs1 and rs2 are always driven from their fixed bit positions, even for formats that do not use them.
- ID_EX_illegal_o = 1 if instr_q[1:0] != 2'b11 or the opcode is not listed above. In that case class = ILLEGAL and imm = 0. The bundle is still handed over normally.

## Timing
- Reset (reset_i high at a clock edge): state = WAIT_INSTR, instr_q = 32'h0000_0013 (NOP).
- Outputs after reset: ID_IF_get_o = 1, ID_EX_give_o = 0, illegal = 0.
- Reset mid-PROVIDE discards the held instruction. No ID_EX_give_o is asserted in the reset cycle.
- If fetch gives in cycle N, the decoded bundle is valid from cycle N+1. The earliest handoff to execute is N+1.
- After a handoff in cycle M, ID_IF_get_o is high again in M+1. Peak throughput is one instruction per 2 cycles.
- If IF_ID_give_i is high while in PROVIDE, it is ignored: no capture, and instr_q is unchanged.
- If EX_ID_get_i is held high continuously, each instruction is handed over exactly once.

## Structure
- Package id_pkg holds:
  - opcode localparams;
  - the class enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, ILLEGAL;
  - the format enum: R, I, S, B, U, J;
  - the FSM state enum.
- One sub-module, id_imm_gen. It is purely combinational: instruction and format in, 32-bit sign-extended immediate out.

## Test plan
- Reset, then fetch gives 0x7C7FE2B7 and execute gets one cycle later -> class LUI, rd=5, imm=0x7C7FE000, illegal=0; give asserted exactly once.
- Give 0x00118193 -> class OPIMM, rd=3, rs1=3, funct3=0, imm=1.
- Give 0xFC7FE2B7 with EX_ID_get_i held low for 5 cycles, then high -> bundle held stable (imm=0xFC7FE000); ID_IF_get_o stays 0 throughout; give pulses once.
- Give 0xFE000EE3 (BEQ x0,x0,-4) -> class BRANCH, imm=0xFFFFFFFC.
- Give 0x00000000 -> illegal=1, class ILLEGAL, imm=0.
- Assert reset_i during PROVIDE with EX_ID_get_i=1 -> ID_EX_give_o=0 that cycle; next cycle state WAIT_INSTR and ID_IF_get_o=1.
